// File: rtl/ddram_arbiter_pkg.sv
// Shared types and constants for the two-client DDRAM arbiter.
// Optional build macro DDRAM_ARB_PRIO_EN selects fixed priority instead of round-robin.
package ddram_arb_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int BE_W   = DATA_W / 8;

    localparam logic C_CPU  = 1'b0;
    localparam logic C_SECD = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WRITE     = 2'd2,
        READ_WAIT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ddram_arbiter_if.sv
// DDRAM Avalon-style master bus: the arbiter uses the master modport, the memory the slave one.
interface ddram_arbiter_if #(
    parameter int CNT_W = 8
);
    import ddram_arb_pkg::*;

    logic              DDRAM_BUSY;
    logic [CNT_W-1:0]  DDRAM_BURSTCNT;
    logic [ADDR_W-1:0] DDRAM_ADDR;
    logic [DATA_W-1:0] DDRAM_DOUT;
    logic              DDRAM_DOUT_READY;
    logic              DDRAM_RD;
    logic [DATA_W-1:0] DDRAM_DIN;
    logic [BE_W-1:0]   DDRAM_BE;
    logic              DDRAM_WE;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

endinterface

// File: rtl/ddram_arbiter_pick.sv
// Combinational two-way picker: round-robin on `last`, or fixed CPU priority
// when DDRAM_ARB_PRIO_EN is defined.
module ddram_arb_pick
    import ddram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = C_CPU;
        if (req == 2'b11) begin
`ifdef DDRAM_ARB_PRIO_EN
            grant = C_CPU;
`else
            grant = ~last;
`endif
        end else if (req[1]) begin
            grant = C_SECD;
        end
    end

`ifdef DDRAM_ARB_PRIO_EN
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/ddram_arbiter.sv
// Shares one 64-bit DDRAM master port between the CPU (client 0) and SECD (client 1) paths.
// Build macro DDRAM_ARB_PRIO_EN (in ddram_arb_pick) switches round-robin to fixed CPU priority.
module ddram_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              DDRAM_CLK,
    input  logic              reset,
    ddram_arbiter_if.master   ddram,

    output logic              c0_busy,
    input  logic [CNT_W-1:0]  c0_burstcnt,
    input  logic [ADDR_W-1:0] c0_addr,
    output logic [DATA_W-1:0] c0_dout,
    output logic              c0_dout_ready,
    input  logic              c0_rd,
    input  logic              c0_we,
    input  logic [DATA_W-1:0] c0_din,
    input  logic [BE_W-1:0]   c0_be,

    output logic              c1_busy,
    input  logic [CNT_W-1:0]  c1_burstcnt,
    input  logic [ADDR_W-1:0] c1_addr,
    output logic [DATA_W-1:0] c1_dout,
    output logic              c1_dout_ready,
    input  logic              c1_rd,
    input  logic              c1_we,
    input  logic [DATA_W-1:0] c1_din,
    input  logic [BE_W-1:0]   c1_be,

    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t       state;
    logic             grant;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic             pick_grant;
    logic             pick_valid;

    logic              own_rd;
    logic              own_we;
    logic [CNT_W-1:0]  own_burst;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_din;
    logic [BE_W-1:0]   own_be;
    logic              own_busy;
    logic              own_ready;
    logic              accept_wr;
    logic              accept_rd;

    ddram_arb_pick u_pick (
        .req   ({c1_rd | c1_we, c0_rd | c0_we}),
        .last  (last),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        if (grant == C_SECD) begin
            own_rd    = c1_rd;
            own_we    = c1_we;
            own_burst = c1_burstcnt;
            own_addr  = c1_addr;
            own_din   = c1_din;
            own_be    = c1_be;
        end else begin
            own_rd    = c0_rd;
            own_we    = c0_we;
            own_burst = c0_burstcnt;
            own_addr  = c0_addr;
            own_din   = c0_din;
            own_be    = c0_be;
        end
    end

    // A write request masks a simultaneous read from the same client.
    assign accept_wr = own_we & ~ddram.DDRAM_BUSY;
    assign accept_rd = own_rd & ~own_we & ~ddram.DDRAM_BUSY;

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            state <= IDLE;
            grant <= C_CPU;
            last  <= C_SECD;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_grant;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!(own_rd || own_we)) begin
                        state <= IDLE;
                    end else if (accept_wr) begin
                        if (own_burst <= CNT_ONE) begin
                            state <= IDLE;
                            last  <= grant;
                        end else begin
                            state <= WRITE;
                            cnt   <= own_burst - CNT_ONE;
                        end
                    end else if (accept_rd) begin
                        state <= READ_WAIT;
                        cnt   <= (own_burst == '0) ? CNT_ONE : own_burst;
                    end
                end
                WRITE: begin
                    if (accept_wr) begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= IDLE;
                            last  <= grant;
                        end
                    end
                end
                READ_WAIT: begin
                    if (ddram.DDRAM_DOUT_READY) begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= IDLE;
                            last  <= grant;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ddram.DDRAM_BURSTCNT = own_burst;
        ddram.DDRAM_ADDR     = own_addr;
        ddram.DDRAM_DIN      = own_din;
        ddram.DDRAM_BE       = own_be;
        ddram.DDRAM_RD       = (state == GRANT) & own_rd & ~own_we;
        ddram.DDRAM_WE       = ((state == GRANT) || (state == WRITE)) & own_we;

        own_busy  = ((state == GRANT) || (state == WRITE)) ? ddram.DDRAM_BUSY : 1'b1;
        own_ready = (state == READ_WAIT) & ddram.DDRAM_DOUT_READY;

        c0_busy       = 1'b1;
        c1_busy       = 1'b1;
        c0_dout_ready = 1'b0;
        c1_dout_ready = 1'b0;
        if (grant == C_SECD) begin
            c1_busy       = own_busy;
            c1_dout_ready = own_ready;
        end else begin
            c0_busy       = own_busy;
            c0_dout_ready = own_ready;
        end
    end

    assign c0_dout   = ddram.DDRAM_DOUT;
    assign c1_dout   = ddram.DDRAM_DOUT;
    assign dbg_state = state;

endmodule
